// File: rtl/glitch_sweep.sv
// glitch_sweep: steps the clock-glitch generator through a 2-D sweep of
// (delay, width) points, one trigger-synchronised glitch per point.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start, abort      begin sweep (IDLE only) / stop sweep (non-IDLE)
//   delay_start/stop/step  outer-loop range, latched on start
//   width_start/stop/step  inner-loop range, latched on start
//   settle            idle cycles between attempts, latched on start
//   trigger           target trigger (rising edge arms a fire)
//   g_ready, g_en     generator handshake
//   g_delay, g_width  current point presented to the generator
//   busy, done        sweep active / one-cycle natural-completion pulse
//   attempts          glitches fired since last start
//
// Build option GLITCH_SWEEP_REPEAT_EN adds rep_count (fires per point
// minus one); it is not called "repeat" because that is a keyword.

module glitch_sweep #(
  parameter int DW = 16,
  parameter int WW = 8,
  parameter int SW = 16,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] delay_start,
  input  logic [DW-1:0] delay_stop,
  input  logic [DW-1:0] delay_step,
  input  logic [WW-1:0] width_start,
  input  logic [WW-1:0] width_stop,
  input  logic [WW-1:0] width_step,
  input  logic [SW-1:0] settle,
`ifdef GLITCH_SWEEP_REPEAT_EN
  input  logic [7:0]    rep_count,
`endif
  input  logic          trigger,
  input  logic          g_ready,
  output logic          g_en,
  output logic [DW-1:0] g_delay,
  output logic [WW-1:0] g_width,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] attempts
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FIRE,
    S_WAIT,
    S_SETTLE,
    S_STEP,
    S_DRAIN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          trig_q;
  logic          trig_edge;

  logic [DW-1:0] d_stop_l;
  logic [DW-1:0] d_step_l;
  logic [WW-1:0] w_start_l;
  logic [WW-1:0] w_stop_l;
  logic [WW-1:0] w_step_l;
  logic [SW-1:0] settle_l;
  logic [SW-1:0] scnt;

  logic [DW-1:0] cur_delay;
  logic [WW-1:0] cur_width;
  logic [CW-1:0] attempts_q;

  // One extra bit catches the carry so an overflow never lands on a
  // small in-range value.
  logic [WW:0]   w_nx;
  logic [DW:0]   d_nx;
  logic          w_ok;
  logic          d_ok;
  logic          rpt_more;

`ifdef GLITCH_SWEEP_REPEAT_EN
  logic [7:0]    rpt_l;
  logic [7:0]    rpt_cnt;
  assign rpt_more = (rpt_cnt != rpt_l);
`else
  assign rpt_more = 1'b0;
`endif

  assign trig_edge = trigger & ~trig_q;

  assign w_nx = {1'b0, cur_width} + {1'b0, w_step_l};
  assign d_nx = {1'b0, cur_delay} + {1'b0, d_step_l};
  assign w_ok = ~w_nx[WW] && (w_nx[WW-1:0] <= w_stop_l);
  assign d_ok = ~d_nx[DW] && (d_nx[DW-1:0] <= d_stop_l);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_ARM;
      S_ARM:    if (trig_edge && g_ready) state_d = S_FIRE;
      S_FIRE:   state_d = S_WAIT;
      S_WAIT:   if (g_ready) state_d = S_SETTLE;
      S_SETTLE: if (scnt == settle_l) state_d = S_STEP;
      S_STEP: begin
        if (rpt_more || w_ok || d_ok) state_d = S_ARM;
        else                          state_d = S_IDLE;
      end
      S_DRAIN:  if (g_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // FIRE still leaves its g_en pulse; only the successor changes.
    if (abort && state_q != S_IDLE && state_q != S_DRAIN)
      state_d = S_DRAIN;
  end

  always_comb begin
    g_en = (state_q == S_FIRE);
    busy = (state_q != S_IDLE);
    done = (state_q == S_STEP) && (state_d == S_IDLE);
  end

  // Edge detector history runs every cycle so a level already high on
  // ARM entry is never mistaken for an edge.
  always_ff @(posedge clk) begin
    trig_q <= trigger;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_stop_l   <= '0;
      d_step_l   <= '0;
      w_start_l  <= '0;
      w_stop_l   <= '0;
      w_step_l   <= '0;
      settle_l   <= '0;
      scnt       <= '0;
      cur_delay  <= '0;
      cur_width  <= '0;
      attempts_q <= '0;
`ifdef GLITCH_SWEEP_REPEAT_EN
      rpt_l      <= '0;
      rpt_cnt    <= '0;
`endif
    end else begin
      if (state_q == S_IDLE && start) begin
        d_stop_l   <= delay_stop;
        d_step_l   <= (delay_step == '0) ? DW'(1) : delay_step;
        w_start_l  <= width_start;
        w_stop_l   <= width_stop;
        w_step_l   <= (width_step == '0) ? WW'(1) : width_step;
        settle_l   <= settle;
        cur_delay  <= delay_start;
        cur_width  <= width_start;
        attempts_q <= '0;
`ifdef GLITCH_SWEEP_REPEAT_EN
        rpt_l      <= rep_count;
        rpt_cnt    <= '0;
`endif
      end
      if (state_q == S_FIRE)
        attempts_q <= attempts_q + CW'(1);
      if (state_q == S_WAIT)
        scnt <= '0;
      else if (state_q == S_SETTLE)
        scnt <= scnt + SW'(1);
      if (state_q == S_STEP && state_d == S_ARM) begin
        if (rpt_more) begin
`ifdef GLITCH_SWEEP_REPEAT_EN
          rpt_cnt <= rpt_cnt + 8'd1;
`endif
        end else begin
`ifdef GLITCH_SWEEP_REPEAT_EN
          rpt_cnt <= '0;
`endif
          if (w_ok) begin
            cur_width <= w_nx[WW-1:0];
          end else begin
            cur_width <= w_start_l;
            cur_delay <= d_nx[DW-1:0];
          end
        end
      end
    end
  end

  assign g_delay  = cur_delay;
  assign g_width  = cur_width;
  assign attempts = attempts_q;

endmodule

// File: tb/tb_glitch_sweep.sv
// tb_glitch_sweep: scoreboard bench for glitch_sweep with a generator
// model, random triggers and a list-based sweep reference model.

module tb_glitch_sweep;

  localparam int DW = 16;
  localparam int WW = 8;
  localparam int SW = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [DW-1:0] delay_start;
  logic [DW-1:0] delay_stop;
  logic [DW-1:0] delay_step;
  logic [WW-1:0] width_start;
  logic [WW-1:0] width_stop;
  logic [WW-1:0] width_step;
  logic [SW-1:0] settle;
`ifdef GLITCH_SWEEP_REPEAT_EN
  logic [7:0]    rep_count;
`endif
  logic          trigger;
  logic          g_ready;
  logic          g_en;
  logic [DW-1:0] g_delay;
  logic [WW-1:0] g_width;
  logic          busy;
  logic          done;
  logic [CW-1:0] attempts;

  glitch_sweep #(.DW(DW), .WW(WW), .SW(SW), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .delay_start (delay_start),
    .delay_stop  (delay_stop),
    .delay_step  (delay_step),
    .width_start (width_start),
    .width_stop  (width_stop),
    .width_step  (width_step),
    .settle      (settle),
`ifdef GLITCH_SWEEP_REPEAT_EN
    .rep_count   (rep_count),
`endif
    .trigger     (trigger),
    .g_ready     (g_ready),
    .g_en        (g_en),
    .g_delay     (g_delay),
    .g_width     (g_width),
    .busy        (busy),
    .done        (done),
    .attempts    (attempts)
  );

  always #5 clk = ~clk;

  logic [DW+WW-1:0] exp_q[$];
  int               done_q[$];
  logic [DW+WW-1:0] p;
  int checks = 0;
  int passes = 0;
  int nfire = 0;
  int ndone = 0;
  int done_base = 0;
  int trig_mode = 0;
  logic trig_force = 1'b0;
  logic prev_en = 1'b0;
  logic after_done = 1'b0;
  int gcnt = 0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Trigger source: random pulses, or a level forced by the sequence.
  initial begin
    trigger = 1'b0;
    forever begin
      @(negedge clk);
      if (trig_mode == 0) trigger = ($urandom_range(0, 5) == 0);
      else                trigger = trig_force;
    end
  end

  // Generator model: drops ready after an accepted en, raises it again
  // after a latency that grows with the requested delay.
  initial begin
    g_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        g_ready = 1'b1;
        gcnt = 0;
      end else if (g_en && g_ready) begin
        g_ready = 1'b0;
        gcnt = int'(g_delay & 16'h7f) + int'(g_width & 8'h0f) + 1;
      end else if (!g_ready) begin
        if (gcnt == 0) g_ready = 1'b1;
        else           gcnt--;
      end
    end
  end

  // Monitor: pops expected points on g_en and expected totals on done.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en = 1'b0;
        after_done = 1'b0;
      end else begin
        if (after_done) begin
          chk("busy_after_done", busy, 0);
          after_done = 1'b0;
        end
        if (g_en) begin
          nfire++;
          chk("en_width", prev_en, 0);
          chk("en_queued", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            p = exp_q.pop_front();
            chk("g_delay", g_delay, p[DW+WW-1:WW]);
            chk("g_width", g_width, p[WW-1:0]);
          end
        end
        prev_en = g_en;
        if (done) begin
          ndone++;
          chk("busy_on_done", busy, 1);
          chk("done_queued", done_q.size() != 0, 1);
          if (done_q.size() != 0) begin
            chk("attempts_at_done", attempts, done_q.pop_front());
            chk("points_left", exp_q.size(), 0);
          end
          after_done = 1'b1;
        end
      end
    end
  end

  // Reference: enumerate the sweep with plain integer loops.
  task automatic plan(int ds, int dst, int dp, int ws, int wst,
                      int wp, int rep);
    int d;
    int w;
    int n;
    int dstep;
    int wstep;
    n = 0;
    dstep = (dp == 0) ? 1 : dp;
    wstep = (wp == 0) ? 1 : wp;
    d = ds;
    do begin
      w = ws;
      do begin
        for (int r = 0; r <= rep; r++) begin
          exp_q.push_back({DW'(d), WW'(w)});
          n++;
        end
        w += wstep;
      end while (w <= wst);
      d += dstep;
    end while (d <= dst);
    done_q.push_back(n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    done_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_sweep(int ds, int dst, int dp, int ws, int wst,
                             int wp, int st, int rep);
    @(negedge clk);
    delay_start = DW'(ds);
    delay_stop  = DW'(dst);
    delay_step  = DW'(dp);
    width_start = WW'(ws);
    width_stop  = WW'(wst);
    width_step  = WW'(wp);
    settle      = SW'(st);
`ifdef GLITCH_SWEEP_REPEAT_EN
    rep_count   = 8'(rep);
`endif
    plan(ds, dst, dp, ws, wst, wp, rep);
    done_base = ndone;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", busy, 1);
    // Config changes and a second start while busy must not matter.
    delay_start = DW'($urandom);
    delay_stop  = DW'($urandom);
    delay_step  = DW'($urandom);
    width_start = WW'($urandom);
    width_stop  = WW'($urandom);
    width_step  = WW'($urandom);
    settle      = SW'($urandom);
`ifdef GLITCH_SWEEP_REPEAT_EN
    rep_count   = 8'($urandom);
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_sweep(int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("sweep_finished", busy, 0);
    if (busy) do_reset();
    chk("done_count", ndone - done_base, 1);
  endtask

  task automatic wait_fire(int budget);
    int n0;
    int k;
    n0 = nfire;
    k = 0;
    while (nfire == n0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("fire_seen", nfire != n0, 1);
  endtask

  task automatic wait_ready(int budget);
    int k;
    k = 0;
    while (!g_ready && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("ready_seen", g_ready, 1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_g_en", g_en, 0);
    chk("rst_g_delay", g_delay, 0);
    chk("rst_g_width", g_width, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_attempts", attempts, 0);
  endtask

  initial begin
    int n0;
    int bad;
    int k;
    int ds, dst, ws, wst;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    delay_start = '0;
    delay_stop = '0;
    delay_step = '0;
    width_start = '0;
    width_stop = '0;
    width_step = '0;
    settle = '0;
`ifdef GLITCH_SWEEP_REPEAT_EN
    rep_count = '0;
`endif
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;

    // Basic 3x2 sweep.
    start_sweep(10, 12, 1, 3, 4, 1, 5, 0);
    finish_sweep(20000);
    chk("attempts_basic", attempts, 6);

    // Width carry, zero steps, inverted range, delay carry.
    start_sweep(0, 0, 1, 250, 255, 4, 2, 0);
    finish_sweep(20000);
    chk("attempts_wcarry", attempts, 2);
    start_sweep(0, 0, 0, 3, 4, 0, 1, 0);
    finish_sweep(20000);
    chk("attempts_step0", attempts, 2);
    start_sweep(1, 1, 1, 7, 2, 1, 0, 0);
    finish_sweep(20000);
    chk("attempts_inverted", attempts, 1);
    start_sweep(65530, 65535, 4, 1, 1, 1, 0, 0);
    finish_sweep(20000);
    chk("attempts_dcarry", attempts, 2);

    // Trigger already high at start must not fire.
    trig_mode = 1;
    trig_force = 1'b1;
    repeat (3) @(negedge clk);
    n0 = nfire;
    start_sweep(4, 4, 1, 2, 2, 1, 0, 0);
    repeat (30) @(negedge clk);
    chk("no_fire_while_high", nfire - n0, 0);
    trig_force = 1'b0;
    repeat (3) @(negedge clk);
    trig_force = 1'b1;
    finish_sweep(2000);
    trig_mode = 0;

    // Long settle with frequent random triggers landing inside it.
    start_sweep(2, 3, 1, 5, 6, 1, 40, 0);
    finish_sweep(20000);
    chk("attempts_settle", attempts, 4);

    // Random sweeps.
    for (int i = 0; i < 8; i++) begin
      ds  = $urandom_range(1, 20);
      dst = ds + $urandom_range(0, 4) - 1;
      ws  = $urandom_range(1, 250);
      wst = ws + $urandom_range(0, 5) - 1;
      if (wst > 255) wst = 255;
`ifdef GLITCH_SWEEP_REPEAT_EN
      start_sweep(ds, dst, $urandom_range(0, 2), ws, wst,
                  $urandom_range(0, 3), $urandom_range(0, 6),
                  $urandom_range(0, 2));
`else
      start_sweep(ds, dst, $urandom_range(0, 2), ws, wst,
                  $urandom_range(0, 3), $urandom_range(0, 6), 0);
`endif
      finish_sweep(20000);
    end

    // Abort while the generator is still busy.
    start_sweep(100, 101, 1, 1, 1, 1, 3, 0);
    wait_fire(2000);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    exp_q.delete();
    done_q.delete();
    @(negedge clk);
    abort = 1'b0;
    bad = 0;
    k = 0;
    while (!g_ready && k < 400) begin
      if (!busy) bad++;
      @(negedge clk);
      k++;
    end
    chk("busy_during_drain", bad, 0);
    chk("drain_ready", g_ready, 1);
    @(negedge clk);
    chk("idle_after_drain", busy, 0);
    chk("no_done_on_abort", ndone - done_base, 0);
    chk("attempts_abort", attempts, 1);
    start_sweep(100, 100, 1, 1, 2, 1, 0, 0);
    finish_sweep(20000);
    chk("attempts_restart", attempts, 2);

    // Reset during SETTLE.
    start_sweep(2, 3, 1, 1, 1, 1, 30, 0);
    wait_fire(2000);
    wait_ready(500);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    done_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs();

`ifdef GLITCH_SWEEP_REPEAT_EN
    start_sweep(5, 5, 1, 1, 2, 1, 2, 2);
    finish_sweep(20000);
    chk("attempts_repeat", attempts, 6);
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
